// File: rtl/alu_seq_stage.sv
// ---------------------------------------------------------------------------
// alu_seq_stage
//   Registered, handshaked ALU stage between the operand/decode front end and
//   register write-back. One operation per transaction: bitwise logic,
//   add/sub (modulo 2^WIDTH) and logical shifts done one bit per cycle.
//   The result is held in DONE until the consumer takes it.
//
//   Optional feature macro: ALU_FLAGS_EN
//     defined   -> zero/carry flags are computed and registered with result
//     undefined -> flag logic is removed, zero and carry are tied to 0
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active-high
//   in_valid   in   1      op/a/b valid
//   in_ready   out  1      stage can accept (IDLE)
//   op         in   4      opcode (0 AND,1 OR,2 NAND,3 XOR,4 NOT a,5 ADD,
//                          6 SUB,7 SHL,8 SHR, 9-15 illegal -> result 0)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B / shift amount (b[SHW-1:0])
//   out_valid  out  1      result valid (DONE)
//   out_ready  in   1      consumer takes result
//   result     out  WIDTH  registered result
//   zero       out  1      result == 0
//   carry      out  1      carry / borrow / last bit shifted out
//
// States
//   state | meaning
//   IDLE  | waiting for an operation, in_ready=1
//   EXEC  | multi-cycle shift in progress, one bit per cycle
//   DONE  | result held, out_valid=1, leaves when out_ready=1
// ---------------------------------------------------------------------------
module alu_seq_stage #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_NAND = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_ADD  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;

    localparam logic [SHW-1:0] CNT_ZERO = '0;
    localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             shr_q, shr_d;
    logic             accept;
    logic [SHW-1:0]   shamt;

    assign accept = in_valid && (state_q == IDLE);
    assign shamt  = b[SHW-1:0];

    // Adder: SUB is a + ~b + 1. The extra top bit (carry-out) exists only
    // when the flags are built in.
`ifdef ALU_FLAGS_EN
    logic [WIDTH:0] add_w;
    logic [WIDTH:0] sub_w;
    assign add_w = {1'b0, a} + {1'b0, b};
    assign sub_w = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
`else
    logic [WIDTH-1:0] add_w;
    logic [WIDTH-1:0] sub_w;
    assign add_w = a + b;
    assign sub_w = a + ~b + {{(WIDTH-1){1'b0}}, 1'b1};
`endif

    // Next-state / datapath
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        shr_d   = shr_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = DONE;
                    cnt_d   = CNT_ZERO;
                    shr_d   = (op == OP_SHR);
                    case (op)
                        OP_AND:  res_d = a & b;
                        OP_OR:   res_d = a | b;
                        OP_NAND: res_d = ~(a & b);
                        OP_XOR:  res_d = a ^ b;
                        OP_NOT:  res_d = ~a;
                        OP_ADD:  res_d = add_w[WIDTH-1:0];
                        OP_SUB:  res_d = sub_w[WIDTH-1:0];
                        OP_SHL, OP_SHR: begin
                            // Load the operand; a zero amount completes at once.
                            res_d = a;
                            if (shamt != CNT_ZERO) begin
                                cnt_d   = shamt;
                                state_d = EXEC;
                            end
                        end
                        default: res_d = '0;
                    endcase
                end
            end

            EXEC: begin
                if (shr_q) begin
                    res_d = {1'b0, res_q[WIDTH-1:1]};
                end else begin
                    res_d = {res_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_ONE;
                // The final shift lands together with the move to DONE.
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            res_q   <= '0;
            cnt_q   <= '0;
            shr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            shr_q   <= shr_d;
        end
    end

`ifdef ALU_FLAGS_EN
    logic zero_q, zero_d;
    logic carry_q, carry_d;

    // Carry follows the same update points as the result register so both
    // stay consistent while DONE holds them.
    always_comb begin
        carry_d = carry_q;
        zero_d  = (res_d == '0);
        if (accept) begin
            case (op)
                OP_ADD:  carry_d = add_w[WIDTH];
                OP_SUB:  carry_d = ~sub_w[WIDTH];
                default: carry_d = 1'b0;
            endcase
        end else if (state_q == EXEC) begin
            carry_d = shr_q ? res_q[0] : res_q[WIDTH-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    assign zero  = zero_q;
    assign carry = carry_q;
`else
    assign zero  = 1'b0;
    assign carry = 1'b0;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = res_q;

endmodule
